// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address and pointer width derivation from DEPTH.
// Used by the single-clock FIFO and the dual-clock FIFO.
package fifo_pkg;

  // Bits needed to address DEPTH entries (at least one).
  function automatic int fifo_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int fifo_ptr_width(input int depth);
    return fifo_addr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock simple dual-port RAM for sync_fifo_flex.
// Synchronous write. Read port is registered (FWFT=0) or combinational (FWFT=1).
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [fifo_addr_width(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic                                rd_en,
  input  logic [fifo_addr_width(DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]               rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read: load the head word on an accepted read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read data register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // In FWFT mode the head word is looked up directly from the array.
  assign rd_data = (FWFT != 0) ? mem_q[rd_addr] : rd_data_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty
// flags and an optional first-word-fall-through read mode.
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow
// flags and the err_clr input.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              w_en,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              r_en,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [fifo_ptr_width(DEPTH)-1:0]  level
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                              err_clr,
  output logic                              overflow,
  output logic                              underflow
`endif
);

  localparam int ADDR_WIDTH = fifo_addr_width(DEPTH);
  localparam int PTR_WIDTH  = fifo_ptr_width(DEPTH);

  logic [PTR_WIDTH-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PTR_WIDTH-1:0]  rd_ptr_d, rd_ptr_q;
  logic [PTR_WIDTH-1:0]  level_d, level_q;
  logic                  full_d, full_q;
  logic                  empty_d, empty_q;
  logic                  afull_d, afull_q;
  logic                  aempty_d, aempty_q;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] mem_rd_data_s;

  // Accept decisions, pointer advance, level and flags from the next level.
  always_comb begin
    wr_acc_s = w_en & ~full_q;
    rd_acc_s = r_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_acc_s);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(rd_acc_s);
    level_d  = level_q + PTR_WIDTH'(wr_acc_s) - PTR_WIDTH'(rd_acc_s);
    full_d   = (level_d == PTR_WIDTH'(DEPTH));
    empty_d  = (level_d == {PTR_WIDTH{1'b0}});
    afull_d  = (level_d >= PTR_WIDTH'(AFULL_THRESH));
    aempty_d = (level_d <= PTR_WIDTH'(AEMPTY_THRESH));
  end

  // Pointer, level and flag registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (mem_rd_data_s)
  );

  // FWFT output is forced to zero while empty so reset presents zero.
  assign data_out = ((FWFT != 0) && empty_q) ? {DATA_WIDTH{1'b0}} : mem_rd_data_s;

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;

  // Sticky error flags: a new error beats a clear in the same cycle.
  always_comb begin
    if (w_en & full_q) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (r_en & empty_q) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read instance and an FWFT instance
// share one stimulus stream and are compared against a queue-based model.
module tb_sync_fifo_flex;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = 8'h00;
  logic          err_clr = 1'b0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0;
  logic          full1, empty1, af1, ae1;
  logic [3:0]    lvl0, lvl1;
`ifdef SYNC_FIFO_ERR_EN
  logic          ovf0, unf0, ovf1, unf1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d0;
  logic          m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                   .AEMPTY_THRESH(AE), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .level(lvl0)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf0), .underflow(unf0)
`endif
  );

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                   .AEMPTY_THRESH(AE), .FWFT(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .level(lvl1)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf1), .underflow(unf1)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic rst, input logic clr);
    int  n;
    bit  wacc, racc;
    logic [DW-1:0] exp_d1;
    @(negedge clk);
    w_en = w; data_in = d; r_en = r; rst_n = ~rst; err_clr = clr;
    @(posedge clk);
    cyc++;
    n = q.size();
    if (rst) begin
      q.delete();
      exp_d0 = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wacc = w && (n < DEPTH);
      racc = r && (n > 0);
      if (w && n == DEPTH) m_ovf = 1'b1;
      else if (clr)        m_ovf = 1'b0;
      if (r && n == 0)     m_unf = 1'b1;
      else if (clr)        m_unf = 1'b0;
      if (racc) exp_d0 = q.pop_front();
      if (wacc) q.push_back(d);
    end
    #1;
    n = q.size();
    exp_d1 = (n > 0) ? q[0] : '0;
    check_val("level",        32'(lvl0), 32'(n));
    check_val("full",         32'(full0), 32'(n == DEPTH));
    check_val("empty",        32'(empty0), 32'(n == 0));
    check_val("almost_full",  32'(af0), 32'(n >= AF));
    check_val("almost_empty", 32'(ae0), 32'(n <= AE));
    check_val("data_out",     32'(dout0), 32'(exp_d0));
    check_val("fw_level",     32'(lvl1), 32'(n));
    check_val("fw_flags",     32'({full1, empty1, af1, ae1}),
              32'({n == DEPTH, n == 0, n >= AF, n <= AE}));
    check_val("fw_data_out",  32'(dout1), 32'(exp_d1));
`ifdef SYNC_FIFO_ERR_EN
    check_val("overflow",     32'({ovf0, ovf1}), 32'({m_ovf, m_ovf}));
    check_val("underflow",    32'({unf0, unf1}), 32'({m_unf, m_unf}));
`endif
  endtask

  initial begin
    q.delete();
    exp_d0 = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // 1. Reset, fill to full, dropped 9th write, drain in order.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 2. Almost flags across thresholds.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 3. Simultaneous requests at full and at empty.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 4. Streaming at level 3 so pointers wrap several times.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 5. Fall-through of a single word.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 6. Reset mid-operation, then error flag handling.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h6F, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with write-heavy and read-heavy phases.
    for (int i = 0; i < 600; i++) begin
      int unsigned pw;
      int unsigned pr;
      pw = ((i / 40) % 2 == 0) ? 75 : 30;
      pr = ((i / 40) % 2 == 0) ? 30 : 75;
      step(($urandom_range(99, 0) < pw) ? 1'b1 : 1'b0,
           8'($urandom_range(255, 0)),
           ($urandom_range(99, 0) < pr) ? 1'b1 : 1'b0,
           ($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
